// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM video arbiter: FSM encoding, bus widths and the
// width helper for the read-credit counter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned BC_W_DEF   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRdCmd,
    StWrBurst
  } arb_state_e;

  // Smallest width able to index v distinct values (never less than 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/sdram_arb_credit.sv
// Outstanding read-word counter. Tracks words requested but not yet returned and reports
// whether a new burst of req_amt_i words would still fit in the return-path credit.
module sdram_arb_credit
  import sdram_arb_pkg::*;
#(
  parameter int unsigned BC_W        = BC_W_DEF,
  parameter int unsigned MAX_PEND_RD = 64,
  localparam int unsigned CNT_W      = clog2(MAX_PEND_RD + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic [BC_W-1:0]  inc_amt_i,
  input  logic             dec_i,
  input  logic [BC_W-1:0]  req_amt_i,
  output logic             eligible_o,
  output logic [CNT_W-1:0] pending_o
);

  localparam int unsigned SUM_W = ((CNT_W > BC_W) ? CNT_W : BC_W) + 1;

  logic [CNT_W-1:0] pending_q, pending_d;
  logic [SUM_W-1:0] req_sum;
  logic [SUM_W-1:0] nxt;

  always_comb begin
    req_sum    = SUM_W'(pending_q) + SUM_W'(req_amt_i);
    eligible_o = (req_sum <= SUM_W'(MAX_PEND_RD));

    nxt = SUM_W'(pending_q);
    if (inc_i) nxt = nxt + SUM_W'(inc_amt_i);
    // A stray valid with nothing outstanding is dropped rather than wrapping.
    if (dec_i && (pending_q != '0)) nxt = nxt - SUM_W'(1);

    if (nxt > SUM_W'(MAX_PEND_RD)) pending_d = CNT_W'(MAX_PEND_RD);
    else                           pending_d = nxt[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/sdram_video_arbiter.sv
// Shares one Avalon-MM SDRAM port between the frame-buffer reader and writer. Whole bursts
// are granted; reads have priority, but a run limit forces a waiting write through.
module sdram_video_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned BC_W        = BC_W_DEF,
  parameter int unsigned MAX_RD_RUN  = 4,
  parameter int unsigned MAX_PEND_RD = 64
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,

  input  logic [ADDR_W-1:0] rd_address,
  input  logic              rd_read,
  input  logic [BC_W-1:0]   rd_burstcount,
  output logic              rd_waitrequest,
  output logic [DATA_W-1:0] rd_readdata,
  output logic              rd_readdatavalid,

  input  logic [ADDR_W-1:0] wr_address,
  input  logic              wr_write,
  input  logic [BC_W-1:0]   wr_burstcount,
  input  logic [DATA_W-1:0] wr_writedata,
  input  logic [1:0]        wr_byteenable,
  output logic              wr_waitrequest,

  output logic [ADDR_W-1:0] sd_address,
  output logic              sd_read,
  output logic              sd_write,
  output logic [BC_W-1:0]   sd_burstcount,
  output logic [DATA_W-1:0] sd_writedata,
  output logic [1:0]        sd_byteenable,
  input  logic              sd_waitrequest,
  input  logic [DATA_W-1:0] sd_readdata,
  input  logic              sd_readdatavalid,

  output logic              starve_evt
);

  localparam int unsigned CNT_W = clog2(MAX_PEND_RD + 1);
  localparam int unsigned RUN_W = clog2(MAX_RD_RUN + 1);

  arb_state_e        state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [BC_W-1:0]   wbc_q, wbc_d;
  logic              starve_q, starve_d;

  logic [BC_W-1:0]   rd_bc, wr_bc;
  logic              rd_ok, rd_acc, wr_acc;
  logic [CNT_W-1:0]  pending;

  // A zero burstcount is issued as a single-word burst.
  assign rd_bc = (rd_burstcount == '0) ? BC_W'(1) : rd_burstcount;
  assign wr_bc = (wr_burstcount == '0) ? BC_W'(1) : wr_burstcount;

  assign rd_acc = (state_q == StRdCmd) && !sd_waitrequest;
  assign wr_acc = (state_q == StWrBurst) && wr_write && !sd_waitrequest;

  sdram_arb_credit #(
    .BC_W        (BC_W),
    .MAX_PEND_RD (MAX_PEND_RD)
  ) u_credit (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .inc_i      (rd_acc),
    .inc_amt_i  (rd_bc),
    .dec_i      (sd_readdatavalid),
    .req_amt_i  (rd_bc),
    .eligible_o (rd_ok),
    .pending_o  (pending)
  );

  // Read return path is a straight passthrough; only the reader ever issues reads.
  assign rd_readdata      = sd_readdata;
  assign rd_readdatavalid = sd_readdatavalid;
  assign starve_evt       = starve_q;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    beat_d   = beat_q;
    first_d  = first_q;
    waddr_d  = waddr_q;
    wbc_d    = wbc_q;
    starve_d = 1'b0;

    sd_read        = 1'b0;
    sd_write       = 1'b0;
    sd_address     = '0;
    sd_burstcount  = '0;
    sd_writedata   = '0;
    sd_byteenable  = '0;
    rd_waitrequest = 1'b1;
    wr_waitrequest = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (wr_write && (run_q == RUN_W'(MAX_RD_RUN))) begin
          state_d  = StWrBurst;
          starve_d = 1'b1;
          run_d    = '0;
          first_d  = 1'b1;
        end else if (rd_read && rd_ok) begin
          state_d = StRdCmd;
        end else if (wr_write) begin
          state_d = StWrBurst;
          run_d   = '0;
          first_d = 1'b1;
        end
      end

      StRdCmd: begin
        sd_read        = 1'b1;
        sd_address     = rd_address;
        sd_burstcount  = rd_bc;
        rd_waitrequest = sd_waitrequest;
        if (!sd_waitrequest) begin
          state_d = StIdle;
          // Only reads that overtook a waiting write count towards the run limit.
          if (wr_write) run_d = (run_q == RUN_W'(MAX_RD_RUN)) ? run_q : run_q + RUN_W'(1);
          else          run_d = '0;
        end
      end

      StWrBurst: begin
        sd_write       = wr_write;
        sd_address     = first_q ? wr_address : waddr_q;
        sd_burstcount  = first_q ? wr_bc : wbc_q;
        sd_writedata   = wr_writedata;
        sd_byteenable  = wr_byteenable;
        wr_waitrequest = sd_waitrequest;
        if (wr_acc) begin
          first_d = 1'b0;
          if (first_q) begin
            waddr_d = wr_address;
            wbc_d   = wr_bc;
            beat_d  = wr_bc - BC_W'(1);
          end else begin
            beat_d  = beat_q - BC_W'(1);
          end
          if (beat_d == '0) state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= StIdle;
      run_q    <= '0;
      beat_q   <= '0;
      first_q  <= 1'b0;
      waddr_q  <= '0;
      wbc_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      beat_q   <= beat_d;
      first_q  <= first_d;
      waddr_q  <= waddr_d;
      wbc_q    <= wbc_d;
      starve_q <= starve_d;
    end
  end

endmodule
